// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared opcode constants, instruction width and fetch FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int INSTR_W = 8;

    localparam logic [2:0] OP_R   = 3'b000;
    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;
    localparam logic [2:0] OP_BEQ = 3'b011;
    localparam logic [2:0] OP_J   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module   : fetch_queue
//  Brief    : 2-entry FIFO of {instr, pc} with flush; head held in output regs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               enq_valid,
    input  logic [INSTR_W-1:0] enq_instr,
    input  logic [PC_W-1:0]    enq_pc,
    input  logic               deq_ready,
    output logic               deq_valid,
    output logic [INSTR_W-1:0] deq_instr,
    output logic [PC_W-1:0]    deq_pc,
    output logic [1:0]         count
);

    logic [INSTR_W-1:0] r_instr0, r_instr1;
    logic [PC_W-1:0]    r_pc0, r_pc1;
    logic [1:0]         r_count;
    logic               w_deq;

    assign w_deq     = deq_ready && (r_count != 2'd0);
    assign deq_valid = (r_count != 2'd0);
    assign deq_instr = r_instr0;
    assign deq_pc    = r_pc0;
    assign count     = r_count;

    // Slot 0 is the head; it only changes when the head leaves or the queue was empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr0 <= '0;
            r_instr1 <= '0;
            r_pc0    <= '0;
            r_pc1    <= '0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({enq_valid, w_deq})
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_instr0 <= r_instr1;
                        r_pc0    <= r_pc1;
                        r_instr1 <= enq_instr;
                        r_pc1    <= enq_pc;
                    end else begin
                        r_instr0 <= enq_instr;
                        r_pc0    <= enq_pc;
                    end
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_instr0 <= r_instr1;
                        r_pc0    <= r_pc1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_instr0 <= enq_instr;
                        r_pc0    <= enq_pc;
                    end else begin
                        r_instr1 <= enq_instr;
                        r_pc1    <= enq_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch stage: PC, single outstanding imem request,
//             2-entry instruction queue, redirect/flush handling.
//             Optional macro JUMP_PREDECODE_EN folds J instructions at fetch.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               id_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc
);

    fetch_state_t    r_state, w_state_next;
    logic [PC_W-1:0] r_pc, w_pc_next, w_jump_pc;
    logic            w_enq, w_flush, w_transfer, w_is_jump;
    logic [1:0]      w_count, w_occ_after;

    assign imem_req    = (r_state != IDLE);
    assign imem_addr   = r_pc;
    assign w_transfer  = if_valid && id_ready;
    assign w_occ_after = w_count - {1'b0, w_transfer};

`ifdef JUMP_PREDECODE_EN
    assign w_is_jump = (imem_data[7:5] == OP_J);
    assign w_jump_pc = PC_W'(imem_data[4:0]);
`else
    assign w_is_jump = 1'b0;
    assign w_jump_pc = r_pc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_enq        = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_occ_after < 2'd2) w_state_next = REQ;
            end
            REQ: begin
                if (imem_valid) begin
                    if (w_is_jump) begin
                        w_pc_next    = w_jump_pc;
                        w_state_next = (w_occ_after < 2'd2) ? REQ : IDLE;
                    end else begin
                        w_enq        = 1'b1;
                        w_pc_next    = r_pc + 1'b1;
                        w_state_next = (w_occ_after == 2'd0) ? REQ : IDLE;
                    end
                end
            end
            DROP: begin
                if (imem_valid) w_state_next = REQ;
            end
            default: w_state_next = IDLE;
        endcase
        // A redirect overrides everything; a still-pending response must be swallowed.
        if (redirect_valid) begin
            w_flush   = 1'b1;
            w_enq     = 1'b0;
            w_pc_next = redirect_pc;
            if (r_state == IDLE) w_state_next = REQ;
            else                 w_state_next = imem_valid ? REQ : DROP;
        end
    end

    fetch_queue #(
        .PC_W (PC_W)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_flush),
        .enq_valid (w_enq),
        .enq_instr (imem_data),
        .enq_pc    (r_pc),
        .deq_ready (id_ready),
        .deq_valid (if_valid),
        .deq_instr (if_instr),
        .deq_pc    (if_pc),
        .count     (w_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Self-checking bench for fetch_unit (memory model + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_data;
    logic       if_valid;
    logic [7:0] if_instr;
    logic [7:0] if_pc;
    logic       id_ready;
    logic       redirect_valid;
    logic [7:0] redirect_pc;

    int vectors;
    int miscompares;
    int lat;
    int r_mcnt;

    typedef struct {
        logic [7:0] start_pc;
        bit         use_redir;
        int         lat;
        int         n;
        int         stall_at;
        int         stall_len;
        int         redir_at;
        logic [7:0] redir_pc;
    } vec_t;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] instr;
    } exp_t;

    vec_t vecs[7];
    exp_t exp_q[$];

    fetch_unit u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: mem[a] = a, except a J (target 0x15) at address 3.
    function automatic logic [7:0] mem_of(input logic [7:0] a);
        return (a == 8'h03) ? 8'b100_10101 : a;
    endfunction

    // Memory answers after 'lat' cycles of request; drops its request on reset.
    always @(posedge clk) begin
        if (reset || !imem_req || imem_valid) r_mcnt <= 0;
        else                                  r_mcnt <= r_mcnt + 1;
    end
    assign imem_valid = imem_req && (r_mcnt == lat);
    assign imem_data  = imem_valid ? mem_of(imem_addr) : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seq(input logic [7:0] start, input int n);
        logic [7:0] pc;
        logic [7:0] ins;
        int cnt;
        pc  = start;
        cnt = 0;
        while (cnt < n) begin
            ins = mem_of(pc);
`ifdef JUMP_PREDECODE_EN
            if (ins[7:5] == 3'b100) begin
                pc = {3'b000, ins[4:0]};
                continue;
            end
`endif
            exp_q.push_back('{pc: pc, instr: ins});
            cnt++;
            pc = pc + 8'd1;
        end
    endtask

    // Reset asserted together with a redirect: reset must win.
    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h77;
        id_ready       = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", {24'd0, if_instr}, 32'd0);
        chk("rst_if_pc",    {24'd0, if_pc},    32'd0);
        redirect_valid = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic run_phase(input int v);
        int  received;
        int  stall_cnt;
        int  cyc;
        bit  redir_done;
        bit  flush_chk;
        bit  fire;
        bit  stalling;
        exp_t e;
        received   = 0;
        stall_cnt  = 0;
        cyc        = 0;
        redir_done = 0;
        flush_chk  = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            #1;
            redirect_valid = 1'b0;
            fire           = 0;
            if (flush_chk) begin
                chk("flush_if_valid", {31'd0, if_valid}, 32'd0);
                flush_chk = 0;
            end
            stalling = (vecs[v].stall_at >= 0) && (received >= vecs[v].stall_at) &&
                       (stall_cnt < vecs[v].stall_len);
            id_ready = !stalling;
            if (stalling) begin
                if (vecs[v].lat == 0 && stall_cnt >= 3) begin
                    chk("stall_imem_req", {31'd0, imem_req}, 32'd0);
                    chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
                end
                if (if_valid) begin
                    chk("stall_if_pc",    {24'd0, if_pc},    {24'd0, exp_q[0].pc});
                    chk("stall_if_instr", {24'd0, if_instr}, {24'd0, exp_q[0].instr});
                end
                stall_cnt++;
            end
            if (cyc == 0 && vecs[v].use_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = vecs[v].start_pc;
            end else if (!redir_done && vecs[v].redir_at >= 0 && received >= vecs[v].redir_at &&
                         ((vecs[v].lat == 0) ? (imem_valid && if_valid && id_ready)
                                             : (imem_req && !imem_valid))) begin
                redirect_valid = 1'b1;
                redirect_pc    = vecs[v].redir_pc;
                fire           = 1;
                redir_done     = 1;
            end
            #1;
            if (if_valid && id_ready) begin
                e = exp_q.pop_front();
                chk("if_pc",    {24'd0, if_pc},    {24'd0, e.pc});
                chk("if_instr", {24'd0, if_instr}, {24'd0, e.instr});
                received++;
            end
            if (fire) begin
                exp_q.delete();
                push_seq(vecs[v].redir_pc, 4);
                flush_chk = 1;
            end
            cyc++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout phase %0d: %0d outputs still outstanding", v, exp_q.size());
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
    endtask

    initial begin
        //            start   redir lat  n  stall_at len redir_at redir_pc
        vecs[0] = '{8'h00, 1'b0, 0, 10, -1, 0, -1, 8'h00};  // streaming 1/clk
        vecs[1] = '{8'h00, 1'b0, 0,  8,  3, 6, -1, 8'h00};  // back-pressure hold
        vecs[2] = '{8'hFE, 1'b1, 0,  5, -1, 0, -1, 8'h00};  // PC wrap FE,FF,00
        vecs[3] = '{8'h00, 1'b0, 3,  6, -1, 0,  2, 8'h40};  // redirect while pending
        vecs[4] = '{8'h10, 1'b1, 0,  6, -1, 0,  3, 8'h80};  // redirect with resp+transfer
        vecs[5] = '{8'h00, 1'b0, 1,  8, -1, 0, -1, 8'h00};  // J at address 3
        vecs[6] = '{8'h30, 1'b1, 2,  8,  2, 4, -1, 8'h00};  // latency plus stall

        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        lat            = 0;

        for (int v = 0; v < 7; v++) begin
            lat = vecs[v].lat;
            do_reset();
            exp_q.delete();
            push_seq(vecs[v].use_redir ? vecs[v].start_pc : 8'h00, vecs[v].n);
            run_phase(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
